// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               - state_t     : loader FSM states
//               - IM_WORD_W   : instruction word width
//               - byte-order constants (opcode [15:9], literal [7:0])
//               - pack_word() : joins the hi/lo stream bytes into one word
// Revision    : 1.0 - initial release
// ============================================================================
package im_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int IM_WORD_W      = 16;
    localparam int IM_BYTE_W      = 8;
    localparam int IM_OPCODE_MSB  = 15;
    localparam int IM_OPCODE_LSB  = 9;
    localparam int IM_LITERAL_MSB = 7;
    localparam int IM_LITERAL_LSB = 0;

    // The first byte of a pair is the high byte: it carries the opcode field
    // (bit 8 travels along unused); the second byte is the literal.
    function automatic logic [IM_WORD_W-1:0] pack_word(
        input logic [IM_BYTE_W-1:0] hi,
        input logic [IM_BYTE_W-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/im_loader_xor_accum.sv
`default_nettype none
// ============================================================================
// Module      : xor_accum
// Description : 8-bit XOR accumulator used for the loader's frame checksum.
//               clr has priority; with clr and en together the accumulator
//               is loaded with din so the first byte of a frame is included.
// Ports       : clk, rst_n (async, active-low), clr, en, din[7:0] -> acc[7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module xor_accum
    import im_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [IM_BYTE_W-1:0] din,
    output logic [IM_BYTE_W-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= en ? din : '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Program loader. Receives a COUNT byte followed by COUNT
//               hi/lo byte pairs over a valid/ready stream, writes each
//               16-bit word into instruction memory at BASE_ADDR+index
//               (wrapping), then raises cpu_run.
// Build macro : IM_LOADER_CHECKSUM_EN - expect a trailing XOR checksum byte
//               (COUNT ^ all data bytes); a mismatch goes to a sticky error.
// Ports       : clk, rst_n (async, active-low)
//               in_data/in_valid/in_ready : byte stream
//               reload                     : synchronous restart
//               im_we/im_addr/im_wdata     : instruction-memory write port
//               cpu_run, busy, error, words_loaded : status
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 reload,
    output logic                 im_we,
    output logic [ADDR_W-1:0]    im_addr,
    output logic [IM_WORD_W-1:0] im_wdata,
    output logic                 cpu_run,
    output logic                 busy,
    output logic                 error,
    output logic [ADDR_W:0]      words_loaded
);

    localparam int CNT_W = ADDR_W + 1;

    state_t                 r_state;
    logic [7:0]             r_hi;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_index;

    logic                   w_accept;
    logic [CNT_W-1:0]       w_count_raw;
    logic [CNT_W-1:0]       w_count_n;
    logic [CNT_W-1:0]       w_index_next;
    logic                   w_last;

    assign in_ready = ((r_state == ST_IDLE) || (r_state == ST_HI) ||
                       (r_state == ST_LO)   || (r_state == ST_CHK)) && !reload;
    assign busy     = (r_state == ST_HI) || (r_state == ST_LO) || (r_state == ST_CHK);
    assign w_accept = in_valid && in_ready;

    // The index only advances together with a write, so it is the word count.
    assign words_loaded = r_index;

    if (ADDR_W >= 8) begin : g_count_wide
        assign w_count_raw = {{(CNT_W-8){1'b0}}, in_data};
    end else begin : g_count_narrow
        assign w_count_raw = in_data[CNT_W-1:0];
    end

    // COUNT of zero encodes a full memory of 2^ADDR_W words.
    assign w_count_n    = (in_data == 8'd0) ? (CNT_W'(1) << ADDR_W) : w_count_raw;
    assign w_index_next = r_index + CNT_W'(1);
    assign w_last       = (w_index_next >= r_count);

`ifdef IM_LOADER_CHECKSUM_EN
    logic       r_error;
    logic [7:0] w_acc;
    logic       w_acc_clr;
    logic       w_acc_en;

    // COUNT restarts the sum; every COUNT/data byte is folded in, the
    // checksum byte itself is only compared.
    assign w_acc_clr = reload || ((r_state == ST_IDLE) && w_accept);
    assign w_acc_en  = w_accept && (r_state != ST_CHK);
    assign error     = r_error;

    xor_accum u_xor_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_acc_clr),
        .en    (w_acc_en),
        .din   (in_data),
        .acc   (w_acc)
    );
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_hi     <= '0;
            r_count  <= '0;
            r_index  <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_run  <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_error  <= 1'b0;
`endif
        end else begin
            im_we <= 1'b0;
            if (reload) begin
                // Partial words are dropped; memory keeps what was written.
                r_state <= ST_IDLE;
                r_index <= '0;
                cpu_run <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
                r_error <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_count <= w_count_n;
                            r_index <= '0;
                            r_state <= ST_HI;
                        end
                    end
                    ST_HI: begin
                        if (w_accept) begin
                            r_hi    <= in_data;
                            r_state <= ST_LO;
                        end
                    end
                    ST_LO: begin
                        if (w_accept) begin
                            im_we    <= 1'b1;
                            im_addr  <= ADDR_W'(BASE_ADDR) + r_index[ADDR_W-1:0];
                            im_wdata <= pack_word(r_hi, in_data);
                            r_index  <= w_index_next;
                            if (!w_last) begin
                                r_state <= ST_HI;
                            end else begin
`ifdef IM_LOADER_CHECKSUM_EN
                                r_state <= ST_CHK;
`else
                                r_state <= ST_DONE;
                                cpu_run <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef IM_LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (w_accept) begin
                            if (in_data == w_acc) begin
                                r_state <= ST_DONE;
                                cpu_run <= 1'b1;
                            end else begin
                                r_state <= ST_ERROR;
                                r_error <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        // DONE and ERROR hold until reload.
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Self-checking bench for im_loader. Two instances share the
//               stimulus: dut_a with BASE_ADDR=0x00 and dut_b with
//               BASE_ADDR=0xF0. Expected writes are queued when a frame is
//               issued; per-instance monitors pop and compare on each im_we.
//               Honours IM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        reload;
    logic [7:0]  in_data;

    logic        in_ready_a, im_we_a, cpu_run_a, busy_a, error_a;
    logic [7:0]  im_addr_a;
    logic [15:0] im_wdata_a;
    logic [8:0]  words_loaded_a;
    logic        in_ready_b, im_we_b, cpu_run_b, busy_b, error_b;
    logic [7:0]  im_addr_b;
    logic [15:0] im_wdata_b;
    logic [8:0]  words_loaded_b;

    im_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .reload(reload), .im_we(im_we_a),
        .im_addr(im_addr_a), .im_wdata(im_wdata_a), .cpu_run(cpu_run_a),
        .busy(busy_a), .error(error_a), .words_loaded(words_loaded_a)
    );

    im_loader #(.ADDR_W(8), .BASE_ADDR(8'hF0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .reload(reload), .im_we(im_we_b),
        .im_addr(im_addr_b), .im_wdata(im_wdata_b), .cpu_run(cpu_run_b),
        .busy(busy_b), .error(error_b), .words_loaded(words_loaded_b)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [8:0]  wl;
        logic        run;
    } wr_t;

    wr_t        q_a[$];
    wr_t        q_b[$];
    wr_t        e_a, e_b;
    logic [7:0] frame_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_cmp(input string tag, input wr_t e, input logic [7:0] a,
                           input logic [15:0] d, input logic [8:0] wl, input logic run);
        checks++;
        if (a !== e.addr || d !== e.data || wl !== e.wl || run !== e.run) begin
            errors++;
            $display("FAIL write_%s: got addr=%h data=%h words=%0d run=%b required addr=%h data=%h words=%0d run=%b",
                     tag, a, d, wl, run, e.addr, e.data, e.wl, e.run);
        end
    endtask

    // Monitors: every write strobe must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && im_we_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_a_extra: got write addr=%h data=%h required no write", im_addr_a, im_wdata_a);
            end else begin
                e_a = q_a.pop_front();
                mon_cmp("a", e_a, im_addr_a, im_wdata_a, words_loaded_a, cpu_run_a);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && im_we_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_b_extra: got write addr=%h data=%h required no write", im_addr_b, im_wdata_b);
            end else begin
                e_b = q_b.pop_front();
                mon_cmp("b", e_b, im_addr_b, im_wdata_b, words_loaded_b, cpu_run_b);
            end
        end
    end

    task automatic push_exp(input int i, input logic [15:0] d, input bit last);
        wr_t w;
        w.addr = 8'(i);
        w.data = d;
        w.wl   = 9'(i + 1);
        w.run  = last && !CK;
        q_a.push_back(w);
        w.addr = 8'(32'hF0 + i);
        q_b.push_back(w);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready_a !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h in_ready=%b required 1 within 50 cycles", b, in_ready_a);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int gap, input bit add_ck);
        int         n;
        logic [7:0] x;
        n = (frame_q[0] == 8'd0) ? 256 : int'(frame_q[0]);
        for (int i = 0; i < n; i++)
            push_exp(i, {frame_q[1 + 2*i], frame_q[2 + 2*i]}, i == n - 1);
        if (CK && add_ck) begin
            x = 8'd0;
            foreach (frame_q[k]) x = x ^ frame_q[k];
            frame_q.push_back(x);
        end
        foreach (frame_q[k]) send_byte(frame_q[k], gap);
    endtask

    task automatic expect_done(input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_pending_a"}, 32'(q_a.size()), 32'd0);
        chk({tag, "_pending_b"}, 32'(q_b.size()), 32'd0);
        chk({tag, "_cpu_run_a"}, 32'(cpu_run_a), 32'd1);
        chk({tag, "_cpu_run_b"}, 32'(cpu_run_b), 32'd1);
        chk({tag, "_in_ready"},  32'(in_ready_a), 32'd0);
        chk({tag, "_busy"},      32'(busy_a), 32'd0);
        chk({tag, "_error"},     32'(error_a), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload();
        @(posedge clk);
        #1;
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_a), 32'd1);
        chk({tag, "_im_we"},    32'(im_we_a), 32'd0);
        chk({tag, "_im_addr"},  32'(im_addr_a), 32'd0);
        chk({tag, "_im_addr_b"}, 32'(im_addr_b), 32'd0);
        chk({tag, "_im_wdata"}, 32'(im_wdata_a), 32'd0);
        chk({tag, "_cpu_run"},  32'(cpu_run_a), 32'd0);
        chk({tag, "_busy"},     32'(busy_a), 32'd0);
        chk({tag, "_error"},    32'(error_a), 32'd0);
        chk({tag, "_words"},    32'(words_loaded_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        reload   = 1'b0;
        in_data  = 8'h00;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic back-to-back load.
        frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(0, 1'b1);
        expect_done("basic");
        do_reload();
        @(negedge clk);
        chk("reload_cpu_run", 32'(cpu_run_a), 32'd0);
        chk("reload_words",   32'(words_loaded_a), 32'd0);
        chk("reload_ready",   32'(in_ready_a), 32'd1);
        @(posedge clk);
        #1;

        // Same frame with 3-cycle stalls between bytes.
        frame_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(3, 1'b1);
        expect_done("stall");
        do_reload();

        // Full 256-word frame; dut_b wraps from 0xFF to 0x00.
        frame_q = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            frame_q.push_back(8'(i));
            frame_q.push_back(~8'(i));
        end
        send_frame(0, 1'b1);
        expect_done("wrap");
        chk("wrap_words", 32'(words_loaded_a), 32'd256);
        chk("wrap_last_addr_b", 32'(im_addr_b), 32'h00EF);
        do_reload();

        // Reload while a word is half received, with a valid byte present.
        push_exp(0, 16'h1122, 1'b0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h44;
        @(negedge clk);
        chk("reload_beat_ready", 32'(in_ready_a), 32'd0);
        @(posedge clk);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midword_busy",    32'(busy_a), 32'd0);
        chk("midword_ready",   32'(in_ready_a), 32'd1);
        chk("midword_cpu_run", 32'(cpu_run_a), 32'd0);
        chk("midword_words",   32'(words_loaded_a), 32'd0);
        chk("midword_pending", 32'(q_a.size()), 32'd0);
        @(posedge clk);
        #1;
        // Loader must be back in IDLE: a fresh frame parses from COUNT.
        frame_q = '{8'h01, 8'h56, 8'h78};
        send_frame(0, 1'b1);
        expect_done("after_reload");
        do_reload();

`ifdef IM_LOADER_CHECKSUM_EN
        // Good checksum: 01 ^ 12 ^ 34 = 27.
        frame_q = '{8'h01, 8'h12, 8'h34, 8'h27};
        send_frame(0, 1'b0);
        expect_done("ck_good");
        do_reload();
        // Bad checksum: sticky error, CPU held.
        frame_q = '{8'h01, 8'h12, 8'h34, 8'h00};
        send_frame(0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ck_bad_error",   32'(error_a), 32'd1);
        chk("ck_bad_cpu_run", 32'(cpu_run_a), 32'd0);
        chk("ck_bad_ready",   32'(in_ready_a), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ck_bad_sticky",  32'(error_a), 32'd1);
        @(posedge clk);
        #1;
        do_reload();
        @(negedge clk);
        chk("ck_reload_error", 32'(error_a), 32'd0);
        chk("ck_reload_ready", 32'(in_ready_a), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Asynchronous reset in the middle of a frame, between edges.
        push_exp(0, 16'h1234, 1'b0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        chk("async_rst_pending", 32'(q_a.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame_q = '{8'h02, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_frame(0, 1'b1);
        expect_done("post_rst");

        chk("final_pending_a", 32'(q_a.size()), 32'd0);
        chk("final_pending_b", 32'(q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/im_loader.md
# im_loader

- Program loader for the 8-bit computer.
- Receives a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instruction words: opcode in [15:9], literal in [7:0].
- Writes each word into the instruction-memory write port, then raises `cpu_run` to release the CPU's fetch path.
- It is the writer side of the instruction memory the CPU reads through its PC/fetch logic.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory address width; word count range is 1..2^ADDR_W.
- `BASE_ADDR`, default 0: address of the first loaded word; addresses wrap modulo 2^ADDR_W.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `reload` in 1: synchronous restart request.
- `im_we` out 1: instruction-memory write strobe.
- `im_addr` out ADDR_W: write address.
- `im_wdata` out 16: write word, high byte first on the stream.
- `cpu_run` out 1: program is complete; the CPU may fetch.
- `busy` out 1: a frame is in progress.
- `error` out 1: frame rejected; sticky until reload or reset.
- `words_loaded` out ADDR_W+1: words written in the current frame.

## Operation
- Frame format: COUNT byte, then 2·N data bytes as hi, lo, hi, lo, … COUNT=0 means N=2^ADDR_W.
- Byte transfer: occurs when `in_valid && in_ready` at a rising edge.
- States: IDLE → HI → LO → (HI or CHK/DONE); ERROR.
  - IDLE: accepts COUNT, latches N, clears the index. Goes to HI.
  - HI: latches the high byte. Goes to LO.
  - LO: on accept, issues the write of {hi, lo} at `BASE_ADDR + index`, then increments index. Goes to HI if index+1 < N, otherwise to DONE (or CHK when configured).
  - DONE: `cpu_run`=1, `in_ready`=0. Stays here until `reload`.
  - ERROR: `error`=1, `cpu_run`=0, `in_ready`=0. Stays here until `reload`.
- `in_ready` = (state ∈ {IDLE, HI, LO, CHK}) && !`reload`.
- `busy` = state ∈ {HI, LO, CHK}.
- `reload` in any state forces IDLE next cycle:
  - Any partial word is discarded and no write is issued.
  - Words already written stay in memory.
  - `cpu_run`, `error` and `words_loaded` clear.
- `reload` during a byte beat: reload wins; the byte is not accepted because `in_ready` is low.
- Addresses wrap: with `BASE_ADDR`=0xF0 and N=32, words go to 0xF0..0xFF, then 0x00..0x0F.

## Timing
- Reset values: `in_ready`=1, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_run`=0, `busy`=0, `error`=0, `words_loaded`=0. State is IDLE.
- `im_we`, `im_addr`, `im_wdata` are registered:
  - `im_we` is high for exactly one cycle, the cycle after the LO byte is accepted.
  - `im_addr`/`im_wdata` hold their values until the next write.
- `words_loaded` increments in the same cycle that `im_we` is high.
- `cpu_run` rises in the same cycle as the final `im_we`. The CPU never runs before the last word is written.
- Back-to-back accepted bytes are supported with no bubbles. Minimum frame time is 1 + 2N cycles.
- Deasserting `in_valid` mid-frame stalls indefinitely; there is no timeout.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). Memory contents are untouched.

## Configuration
- `IM_LOADER_CHECKSUM_EN` defined:
  - After the last LO byte, go to CHK and accept one checksum byte.
  - The checksum byte must equal the XOR of COUNT and all data bytes.
  - Match → DONE. Mismatch → ERROR.
  - Words already written remain in memory; `cpu_run` stays 0.
- Not defined: CHK and ERROR are unreachable. The frame ends at the last LO byte → DONE. `error` is tied to 0.

## Structure
- `im_loader_pkg` holds:
  - the state enum (IDLE, HI, LO, CHK, DONE, ERROR);
  - the `IM_WORD_W`=16 constant;
  - the byte-order constants (opcode field [15:9], literal [7:0]).
- One sub-module is natural: `xor_accum`, an 8-bit XOR accumulator with clear and enable, instantiated only under `IM_LOADER_CHECKSUM_EN`.

## Test plan
- Basic load:
  - Stimulus: stream 02, 12, 34, AB, CD back-to-back.
  - Required: `im_we` pulses at 0x00 with 0x1234, then at 0x01 with 0xABCD.
  - `cpu_run`=1 in the cycle of the second write; `in_ready`=0 afterwards.
- Stall:
  - Stimulus: same stream with `in_valid` low for 3 cycles between each byte.
  - Required: identical writes; no extra or duplicate `im_we`.
- Wrap/max:
  - Stimulus: `BASE_ADDR`=0xF0, COUNT=00, 512 data bytes.
  - Required: 256 writes, the last at address 0xEF; `words_loaded`=256.
- Reload mid-word:
  - Stimulus: 03, 11, 22, 33, then `reload` together with a valid byte 44.
  - Required: byte 44 is not accepted; exactly one write (0x1122); next state IDLE.
  - Required: `cpu_run`=0, `words_loaded`=0.
- Checksum (macro on):
  - Stimulus: 01, 12, 34, checksum 27.
  - Required: DONE.
  - Stimulus: same frame with checksum 00.
  - Required: `error`=1, `cpu_run`=0, until `reload`.
- Async reset:
  - Stimulus: assert `rst_n`=0 mid-frame between clock edges.
  - Required: outputs take reset values immediately; a fresh frame afterwards loads correctly.
